// File: rtl/mmu_table_loader.sv
// Reload sequencer for the MMU entries: invalidates the selected spaces, then walks an in-memory table.
// Optional MMU_LOADER_RESTORE_EN saves the mmu selector before the reload and restores it afterwards.
module mmu_table_loader #(
  parameter int RV   = 16,
  parameter int NMMU = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    space_mask,
  input  logic [RV-1:0] table_base,
  output logic          busy,
  output logic          done,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [RV-1:0] mem_rdata,
  output logic [3:0]    inv_mmu,
  output logic          reg_write,
  output logic [RV-1:0] reg_data,
  input  logic [RV-1:0] reg_read
);

  localparam int IDXW  = $clog2(NMMU);
  localparam int SHIFT = $clog2(RV / 8);

  typedef enum logic [2:0] {
    IDLE, SAVE, INV, FETCH, SEL, ENT, RESTORE, DONE
  } state_t;

  state_t          state;
  logic [3:0]      mask_reg;
  logic [RV-1:0]   base_reg;
  logic [1:0]      space_reg;
  logic [IDXW-1:0] idx_reg;
  logic [RV-2:0]   word_reg;
  logic [RV-2:0]   saved_reg;
  logic            unused_bits;

  // Bit 0 of the table word and of the saved selector is replaced on write-back.
  assign unused_bits = mem_rdata[0] ^ (^reg_read);

  // Returns {found, space} for the lowest set mask bit at or above 'from'.
  function automatic logic [2:0] find_space(input logic [3:0] m, input logic [2:0] from);
    logic [2:0] r;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      if (m[i] && 3'(i) >= from) r = {1'b1, 2'(i)};
    end
    return r;
  endfunction

  // Table word offset is s*NMMU + idx, which is {s, idx} because NMMU is a power of 2.
  function automatic logic [RV-1:0] word_addr(input logic [RV-1:0] base, input logic [1:0] s,
                                               input logic [IDXW-1:0] idx);
    return base + (RV'({s, idx}) << SHIFT);
  endfunction

  function automatic logic [RV-1:0] selector(input logic [1:0] s, input logic [IDXW-1:0] idx);
    logic [RV-1:0] r;
    r = '0;
    r[RV-1 -: IDXW] = idx;
    r[3] = s[0];
    r[2] = s[1];
    return r;
  endfunction

  logic [2:0] first_space;
  logic [2:0] later_space;
  assign first_space = find_space(mask_reg, 3'd0);
  assign later_space = find_space(mask_reg, {1'b0, space_reg} + 3'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      inv_mmu   <= 4'b0000;
      reg_write <= 1'b0;
      reg_data  <= '0;
      mask_reg  <= 4'b0000;
      base_reg  <= '0;
      space_reg <= 2'd0;
      idx_reg   <= '0;
      word_reg  <= '0;
      saved_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mask_reg <= space_mask;
            base_reg <= table_base;
            busy     <= 1'b1;
            if (space_mask == 4'b0000) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
`ifdef MMU_LOADER_RESTORE_EN
              state   <= SAVE;
`else
              inv_mmu <= space_mask;
              state   <= INV;
`endif
            end
          end
        end
        SAVE: begin
          saved_reg <= reg_read[RV-1:1];
          inv_mmu   <= mask_reg;
          state     <= INV;
        end
        INV: begin
          inv_mmu   <= 4'b0000;
          space_reg <= first_space[1:0];
          idx_reg   <= '0;
          mem_req   <= 1'b1;
          mem_addr  <= word_addr(base_reg, first_space[1:0], '0);
          state     <= FETCH;
        end
        FETCH: begin
          if (mem_ack) begin
            word_reg  <= mem_rdata[RV-1:1];
            mem_req   <= 1'b0;
            reg_write <= 1'b1;
            reg_data  <= selector(space_reg, idx_reg);
            state     <= SEL;
          end
        end
        SEL: begin
          reg_data <= {word_reg, 1'b1};
          state    <= ENT;
        end
        ENT: begin
          // The advance-to-next-entry step is folded in here so FETCH follows with no idle cycle.
          if (idx_reg != IDXW'(NMMU - 1)) begin
            idx_reg   <= idx_reg + IDXW'(1);
            reg_write <= 1'b0;
            mem_req   <= 1'b1;
            mem_addr  <= word_addr(base_reg, space_reg, idx_reg + IDXW'(1));
            state     <= FETCH;
          end else if (later_space[2]) begin
            space_reg <= later_space[1:0];
            idx_reg   <= '0;
            reg_write <= 1'b0;
            mem_req   <= 1'b1;
            mem_addr  <= word_addr(base_reg, later_space[1:0], '0);
            state     <= FETCH;
          end else begin
`ifdef MMU_LOADER_RESTORE_EN
            reg_data  <= {saved_reg, 1'b0};
            state     <= RESTORE;
`else
            reg_write <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
`endif
          end
        end
        RESTORE: begin
          reg_write <= 1'b0;
          done      <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
